prbs_draw: RTL

Parametrised Fibonacci LFSR with a request/valid draw engine that returns a bounded random index in [0, RANGE-1]. It succeeds the fixed 16-bit PRBS generator and sits between the game controller and the mole/LED selection logic. It adds:
- configurable width, taps and seed;
- runtime seed loading;
- free-running entropy accumulation while idle;
- rejection sampling with a bounded retry count and a deterministic fallback.

---
 rtl/prbs_draw.sv | 115 +++++++++++
 1 files changed

// File: rtl/prbs_draw.sv
// prbs_draw: Fibonacci LFSR with a req/valid draw engine returning a bounded random index.
// Optional build macro PRBS_NO_REPEAT_EN rejects an index equal to the previous accepted one.
module prbs_draw #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS   = 16'h9C00,
    parameter logic [WIDTH-1:0] SEED   = '1,
    parameter int              STEPS   = 4,
    parameter int              IDX_W   = 4,
    parameter int              RANGE   = 9,
    parameter int              MAX_TRY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             free_run,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] lfsr_out
);
    localparam int SW = $clog2(STEPS + 1);
    localparam int TW = $clog2(MAX_TRY + 1);
    localparam logic [IDX_W:0]   RANGE_V = (IDX_W + 1)'(RANGE);
    localparam logic [IDX_W-1:0] LAST_V  = IDX_W'(RANGE - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_lfsr;
    logic [SW-1:0]    r_step;
    logic [TW-1:0]    r_try;
    logic [IDX_W-1:0] r_idx, r_last;
    logic             r_valid;

    logic [WIDTH-1:0] w_shift;
    logic [IDX_W-1:0] w_cand, w_fallback;
    logic             w_in_range, w_accept, w_step_done, w_last_try;

    assign w_shift     = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    assign w_cand      = r_lfsr[IDX_W-1:0];
    assign w_in_range  = {1'b0, w_cand} < RANGE_V;
    assign w_fallback  = (r_last == LAST_V) ? '0 : r_last + 1'b1;
    assign w_step_done = r_step == SW'(STEPS - 1);
    assign w_last_try  = r_try == TW'(MAX_TRY - 1);
`ifdef PRBS_NO_REPEAT_EN
    // a single-valued range can never avoid repeating, so it always accepts
    assign w_accept    = w_in_range && ((w_cand != r_last) || (RANGE == 1));
`else
    assign w_accept    = w_in_range;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req ? SHIFT : IDLE;
            SHIFT:   w_next = w_step_done ? CHECK : SHIFT;
            CHECK:   w_next = (w_accept || w_last_try) ? IDLE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_lfsr  <= SEED;
            r_step  <= '0;
            r_try   <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_step <= '0;
                        r_try  <= '0;
                    end else if (seed_load) begin
                        r_lfsr <= (seed_in == '0) ? SEED : seed_in;
                    end else if (free_run) begin
                        r_lfsr <= w_shift;
                    end
                end
                SHIFT: begin
                    r_lfsr <= w_shift;
                    r_step <= r_step + 1'b1;
                end
                CHECK: begin
                    if (w_accept) begin
                        r_idx   <= w_cand;
                        r_last  <= w_cand;
                        r_valid <= 1'b1;
                    end else if (w_last_try) begin
                        r_idx   <= w_fallback;
                        r_valid <= 1'b1;
                    end else begin
                        r_try  <= r_try + 1'b1;
                        r_step <= '0;
                    end
                end
                default: ;
            endcase
            // zero lockup recovery overrides any other register update
            if (r_lfsr == '0) r_lfsr <= SEED;
        end
    end

    assign busy     = r_state != IDLE;
    assign valid    = r_valid;
    assign idx      = r_idx;
    assign lfsr_out = r_lfsr;
endmodule
